// File: rtl/event_conv_3x3.sv
// rtl/event_conv_3x3.sv - event-driven 3x3 convolution stage with saturating per-channel update
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   enable                        gates acceptance of new events only
//   event_valid, event_ready      spike event handshake
//   event_x, event_y              event coordinate
//   kernel_weights                signed weight for slot k, channel c at [(k*CHANNELS+c)*B +: B]
//   rd_req, rd_coord, rd_data     arbiter read port, coord {y, x}, data one cycle after request
//   wr_req, wr_coord, wr_data     arbiter write port, coord {y, x}
//   busy, done                    event in progress, one-cycle completion pulse
module event_conv_3x3 #(
    parameter int COORD_BITS       = 4,
    parameter int CHANNELS         = 4,
    parameter int BITS_PER_CHANNEL = 8,
    parameter int IMG_WIDTH        = 16,
    parameter int IMG_HEIGHT       = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enable,
    input  logic                                     event_valid,
    output logic                                     event_ready,
    input  logic [COORD_BITS-1:0]                    event_x,
    input  logic [COORD_BITS-1:0]                    event_y,
    input  logic [9*CHANNELS*BITS_PER_CHANNEL-1:0]   kernel_weights,
    output logic                                     rd_req,
    output logic [2*COORD_BITS-1:0]                  rd_coord,
    input  logic [CHANNELS*BITS_PER_CHANNEL-1:0]     rd_data,
    output logic                                     wr_req,
    output logic [2*COORD_BITS-1:0]                  wr_coord,
    output logic [CHANNELS*BITS_PER_CHANNEL-1:0]     wr_data,
    output logic                                     busy,
    output logic                                     done
);
    localparam int B  = BITS_PER_CHANNEL;
    localparam int CW = CHANNELS * B;
    // Two extra bits so x-1 and x+1 never alias a legal coordinate.
    localparam int XW = COORD_BITS + 2;
    localparam logic [XW-1:0] W_LIM = XW'(IMG_WIDTH);
    localparam logic [XW-1:0] H_LIM = XW'(IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              k_q, k_d;
    logic                    drain_q, drain_d;
    logic [COORD_BITS-1:0]   x_q, y_q;
    logic                    ev_ok_q;
    // Holds event_ready low while reset is asserted and on the first cycle after.
    logic                    live_q;

    logic                    accept;
    logic                    ev_in;
    logic                    issue;
    logic [3:0]              issue_k;
    logic [COORD_BITS-1:0]   base_x, base_y;
    logic                    base_ok;
    logic [1:0]              col, row;
    logic [XW-1:0]           nx, ny;
    logic                    nb_ok;

    // Slot tags: stage 0 travels with rd_req/rd_coord, stage 1 lines up with rd_data.
    logic [3:0]              t0_k;
    logic                    t1_valid;
    logic [3:0]              t1_k;
    logic [2*COORD_BITS-1:0] t1_coord;

    logic [CW-1:0]           sat_data;
    logic [B-1:0]            pix, wgt;
    logic [B:0]              sum;

    assign event_ready = live_q && enable && (state_q == S_IDLE);
    assign accept      = event_valid && event_ready;
    assign ev_in       = ({2'b00, event_x} < W_LIM) && ({2'b00, event_y} < H_LIM);

    // Next-state and slot selection. The slot put on the read port at the
    // coming edge is slot 0 on acceptance, else the slot after k_q.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        issue   = 1'b0;
        issue_k = 4'd0;
        base_x  = x_q;
        base_y  = y_q;
        base_ok = ev_ok_q;
        case (state_q)
            S_IDLE: begin
                base_x  = event_x;
                base_y  = event_y;
                base_ok = ev_in;
                if (accept) begin
                    state_d = S_READ;
                    k_d     = 4'd0;
                    issue   = 1'b1;
                end
            end
            S_READ: begin
                if (k_q == 4'd8) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    issue   = 1'b1;
                    issue_k = k_q + 4'd1;
                    k_d     = k_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raster position of slot k within the 3x3 window.
    always_comb begin
        col = 2'd0;
        row = 2'd0;
        case (issue_k)
            4'd0: begin col = 2'd0; row = 2'd0; end
            4'd1: begin col = 2'd1; row = 2'd0; end
            4'd2: begin col = 2'd2; row = 2'd0; end
            4'd3: begin col = 2'd0; row = 2'd1; end
            4'd4: begin col = 2'd1; row = 2'd1; end
            4'd5: begin col = 2'd2; row = 2'd1; end
            4'd6: begin col = 2'd0; row = 2'd2; end
            4'd7: begin col = 2'd1; row = 2'd2; end
            4'd8: begin col = 2'd2; row = 2'd2; end
            default: begin col = 2'd0; row = 2'd0; end
        endcase
    end

    // A neighbour left of/above the edge wraps to all ones, so the MSB flags it.
    assign nx    = {2'b00, base_x} + {{COORD_BITS{1'b0}}, col} - XW'(1);
    assign ny    = {2'b00, base_y} + {{COORD_BITS{1'b0}}, row} - XW'(1);
    assign nb_ok = !nx[XW-1] && !ny[XW-1] && (nx < W_LIM) && (ny < H_LIM);

    always_comb begin
        sat_data = '0;
        pix      = '0;
        wgt      = '0;
        sum      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pix = rd_data[c*B +: B];
            wgt = kernel_weights[(int'(t1_k)*CHANNELS + c)*B +: B];
            sum = {pix[B-1], pix} + {wgt[B-1], wgt};
            // Sign bits disagree only on overflow; clamp toward the true sign.
            if (sum[B] != sum[B-1]) begin
                sat_data[c*B +: B] = sum[B] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
            end else begin
                sat_data[c*B +: B] = sum[B-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            drain_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ev_ok_q <= 1'b0;
            live_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            live_q  <= 1'b1;
            if (accept) begin
                x_q     <= event_x;
                y_q     <= event_y;
                ev_ok_q <= ev_in;
            end
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req   <= 1'b0;
            rd_coord <= '0;
            t0_k     <= 4'd0;
            t1_valid <= 1'b0;
            t1_k     <= 4'd0;
            t1_coord <= '0;
            wr_req   <= 1'b0;
            wr_coord <= '0;
            wr_data  <= '0;
        end else begin
            rd_req <= issue && base_ok && nb_ok;
            if (issue) begin
                t0_k <= issue_k;
            end
            if (issue && base_ok && nb_ok) begin
                rd_coord <= {ny[COORD_BITS-1:0], nx[COORD_BITS-1:0]};
            end
            t1_valid <= rd_req;
            t1_k     <= t0_k;
            t1_coord <= rd_coord;
            wr_req   <= t1_valid;
            if (t1_valid) begin
                wr_coord <= t1_coord;
                wr_data  <= sat_data;
            end
        end
    end

endmodule

// File: tb/tb_event_conv_3x3.sv
// tb/tb_event_conv_3x3.sv - self-checking bench for event_conv_3x3
module tb_event_conv_3x3;
    localparam int CB = 5;
    localparam int CH = 4;
    localparam int B  = 8;
    localparam int IW = 16;
    localparam int IH = 16;
    localparam int CW = CH * B;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            event_valid = 1'b0;
    logic            event_ready;
    logic [CB-1:0]   event_x = '0;
    logic [CB-1:0]   event_y = '0;
    logic [9*CW-1:0] kernel_weights = '0;
    logic            rd_req;
    logic [2*CB-1:0] rd_coord;
    logic [CW-1:0]   rd_data = '0;
    logic            wr_req;
    logic [2*CB-1:0] wr_coord;
    logic [CW-1:0]   wr_data;
    logic            busy;
    logic            done;

    event_conv_3x3 #(
        .COORD_BITS(CB), .CHANNELS(CH), .BITS_PER_CHANNEL(B),
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_x(event_x), .event_y(event_y),
        .kernel_weights(kernel_weights),
        .rd_req(rd_req), .rd_coord(rd_coord), .rd_data(rd_data),
        .wr_req(wr_req), .wr_coord(wr_coord), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Arbiter/memory model: one-cycle read latency, writes land at the edge.
    logic [CW-1:0] mem [IH][IW];
    logic          pl_en = 1'b0;
    logic [3:0]    pl_x = '0, pl_y = '0;
    logic [CW-1:0] pl_val = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_req) begin
            if (!rd_coord[2*CB-1] && !rd_coord[CB-1]) rd_data <= mem[rd_coord[CB+3:CB]][rd_coord[3:0]];
            else rd_data <= '0;
        end
        if (wr_req && !wr_coord[2*CB-1] && !wr_coord[CB-1]) mem[wr_coord[CB+3:CB]][wr_coord[3:0]] <= wr_data;
        if (pl_en) mem[pl_y][pl_x] <= pl_val;
    end

    typedef struct {
        int              edge_n;
        logic [2*CB-1:0] coord;
        logic [CW-1:0]   data;
    } exp_t;

    typedef struct {
        logic [7:0] stored;
        logic [7:0] weight;
        logic [7:0] expect_v;
    } sat_vec_t;

    exp_t rdq[$];
    exp_t wrq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    // Reference: saturating add of memory and weight for every in-bounds slot.
    task automatic push_expect(input logic [CB-1:0] ex, input logic [CB-1:0] ey, input int hs);
        exp_t          e;
        int            nx, ny, s;
        logic [CW-1:0] d;
        logic [7:0]    a, w;
        if (int'(ex) >= IW || int'(ey) >= IH) return;
        for (int k = 0; k < 9; k++) begin
            nx = int'(ex) + (k % 3) - 1;
            ny = int'(ey) + (k / 3) - 1;
            if (nx < 0 || nx >= IW || ny < 0 || ny >= IH) continue;
            for (int c = 0; c < CH; c++) begin
                a = mem[ny][nx][c*B +: B];
                w = kernel_weights[(k*CH + c)*B +: B];
                s = int'($signed(a)) + int'($signed(w));
                if (s > 127) s = 127;
                if (s < -128) s = -128;
                d[c*B +: B] = 8'(s);
            end
            e.edge_n = hs + k;
            e.coord  = {CB'(ny), CB'(nx)};
            e.data   = d;
            rdq.push_back(e);
            e.edge_n = hs + k + 2;
            wrq.push_back(e);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every request.
    bit   act = 1'b0;
    int   act_hs = 0;
    int   n_rel;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rdq.delete();
                wrq.delete();
                act = 1'b0;
            end else begin
                if (rd_req) begin
                    if (rdq.size() == 0) chk("rd_unexpected", 64'(rd_coord), 64'h3ff_0000);
                    else begin
                        mon_e = rdq.pop_front();
                        chk("rd_cycle", 64'(cyc), 64'(mon_e.edge_n));
                        chk("rd_coord", 64'(rd_coord), 64'(mon_e.coord));
                    end
                end
                if (wr_req) begin
                    if (wrq.size() == 0) chk("wr_unexpected", 64'(wr_coord), 64'h3ff_0000);
                    else begin
                        mon_e = wrq.pop_front();
                        chk("wr_cycle", 64'(cyc), 64'(mon_e.edge_n));
                        chk("wr_coord", 64'(wr_coord), 64'(mon_e.coord));
                        chk("wr_data", 64'(wr_data), 64'(mon_e.data));
                    end
                end
                if (act) begin
                    n_rel = cyc - act_hs;
                    if (n_rel <= 11) begin
                        chk("busy_active", 64'(busy), 64'd1);
                        chk("ready_active", 64'(event_ready), 64'd0);
                        chk("done_timing", 64'(done), 64'(n_rel == 11));
                    end else begin
                        chk("busy_end", 64'(busy), 64'd0);
                        chk("ready_end", 64'(event_ready), 64'(enable));
                        chk("sb_rd_empty", 64'(rdq.size()), 64'd0);
                        chk("sb_wr_empty", 64'(wrq.size()), 64'd0);
                        act = 1'b0;
                    end
                end else begin
                    chk("busy_idle", 64'(busy), 64'd0);
                    chk("done_idle", 64'(done), 64'd0);
                end
                if (event_valid && event_ready) begin
                    act    = 1'b1;
                    act_hs = cyc + 1;
                    push_expect(event_x, event_y, act_hs);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int x, input int y, input logic [CW-1:0] v);
        pl_x = 4'(x); pl_y = 4'(y); pl_val = v; pl_en = 1'b1;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 30; i++) begin
            if (event_ready) break;
            tick();
        end
        chk("accept_timeout", 64'(event_ready), 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) break;
        end
        chk("done_seen", 64'(done), 64'd1);
        tick();
    endtask

    task automatic send(input int x, input int y);
        event_x = CB'(x); event_y = CB'(y); event_valid = 1'b1;
        wait_ready();
        tick();
        event_valid = 1'b0;
        wait_done();
    endtask

    sat_vec_t      vecs[7];
    logic [CW-1:0] v;
    int            hs1, hs2;

    initial begin
        vecs[0] = '{8'h7E, 8'h05, 8'h7F};
        vecs[1] = '{8'h82, 8'hF0, 8'h80};
        vecs[2] = '{8'h10, 8'hF0, 8'h00};
        vecs[3] = '{8'h7F, 8'h7F, 8'h7F};
        vecs[4] = '{8'h80, 8'h80, 8'h80};
        vecs[5] = '{8'hC0, 8'h30, 8'hF0};
        vecs[6] = '{8'h05, 8'hFB, 8'h00};

        enable = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(event_ready), 64'd0);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_rd_coord", 64'(rd_coord), 64'd0);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_wr_coord", 64'(wr_coord), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) preload(x, y, '0);

        // Interior event with a ramp pattern and unit weights.
        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < CH; c++) v[c*B +: B] = 8'(8'h10 + 4*i + c);
            preload(4 + i % 3, 4 + i / 3, v);
        end
        kernel_weights = {36{8'h01}};
        send(5, 5);
        for (int i = 0; i < 9; i++) begin
            for (int c = 0; c < CH; c++) v[c*B +: B] = 8'(8'h11 + 4*i + c);
            chk("interior_mem", 64'(mem[4 + i / 3][4 + i % 3]), 64'(v));
        end

        // Corner event: only slots 4,5,7,8 may touch the arbiter.
        send(0, 0);

        // Saturation vectors applied at the centre pixel.
        for (int i = 0; i < 7; i++) begin
            preload(5, 5, {4{vecs[i].stored}});
            kernel_weights = {36{vecs[i].weight}};
            send(5, 5);
            chk("sat_vec", 64'(mem[5][5]), 64'({4{vecs[i].expect_v}}));
        end

        // Back-to-back events with event_valid held high.
        kernel_weights = {36{8'h01}};
        event_x = CB'(5); event_y = CB'(5); event_valid = 1'b1;
        wait_ready();
        tick();
        hs1 = cyc;
        event_x = CB'(6); event_y = CB'(6);
        wait_ready();
        tick();
        hs2 = cyc;
        event_valid = 1'b0;
        chk("b2b_spacing", 64'(hs2 - hs1), 64'd13);
        wait_done();

        // Reset in cycle 6 of an event.
        event_x = CB'(5); event_y = CB'(5); event_valid = 1'b1;
        wait_ready();
        tick();
        event_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(event_ready), 64'd0);
        chk("mid_rst_rd_req", 64'(rd_req), 64'd0);
        chk("mid_rst_wr_req", 64'(wr_req), 64'd0);
        chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        send(5, 5);

        // enable low blocks acceptance.
        enable = 1'b0;
        event_x = CB'(7); event_y = CB'(7); event_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ready_disabled", 64'(event_ready), 64'd0);
            chk("rd_disabled", 64'(rd_req), 64'd0);
        end
        // enable dropping mid-event does not abort it.
        enable = 1'b1;
        wait_ready();
        tick();
        event_x = CB'(8); event_y = CB'(8);
        tick();
        tick();
        tick();
        enable = 1'b0;
        wait_done();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ready_gated", 64'(event_ready), 64'd0);
            chk("busy_gated", 64'(busy), 64'd0);
        end
        enable = 1'b1;
        wait_ready();
        tick();
        event_valid = 1'b0;
        wait_done();

        // Out-of-range events: accepted, no traffic, still complete.
        send(16, 3);
        send(3, 16);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/event_conv_3x3.md
# event_conv_3x3

Event-driven 3x3 convolution stage that sits directly upstream of the feature-map arbiter's conv read/write ports. For each accepted input spike event at (x, y), it reads the 3x3 neighbourhood of per-channel membrane values through the arbiter read port, adds the matching signed kernel weight per channel with saturation, and writes each result back to the same coordinate through the arbiter write port. Reads and writes are pipelined, so a full interior event completes in a fixed number of cycles.

## Interface
- COORD_BITS, 4: width of each x/y coordinate.
- CHANNELS, 4: number of feature maps packed per pixel.
- BITS_PER_CHANNEL, 8: signed width of each channel value and each weight.
- IMG_WIDTH, 16; IMG_HEIGHT, 16: image bounds; valid coordinates are 0..IMG_WIDTH-1 and 0..IMG_HEIGHT-1.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  gates acceptance of new events only.
- event_valid  in  1  spike event offered.
- event_ready  out  1  block can accept an event this cycle.
- event_x, event_y  in  COORD_BITS each  event coordinate.
- kernel_weights  in  9*CHANNELS*BITS_PER_CHANNEL  weight for position k, channel c at bits [(k*CHANNELS+c)*B +: B]; k=(dy+1)*3+(dx+1); must be stable while busy=1.
- rd_req  out  1  arbiter read request.
- rd_coord  out  2*COORD_BITS  read coordinate, {y, x}.
- rd_data  in  CHANNELS*B  arbiter read data, channel c at [c*B +: B]; valid the cycle after rd_req is sampled.
- wr_req  out  1  arbiter write request.
- wr_coord  out  2*COORD_BITS  write coordinate, {y, x}.
- wr_data  out  CHANNELS*B  write data, same packing as rd_data.
- busy  out  1  event in progress.
- done  out  1  one-cycle pulse at event completion.

## Operation
- States: IDLE, READ (position counter k=0..8), DRAIN (2 cycles), DONE.
- IDLE: event_ready = enable. The handshake (event_valid && event_ready) latches x and y and moves to READ with k=0.
- READ: each cycle, compute the neighbour (x+dx, y+dy) with dx,dy in {-1,0,1} in raster order (k=0 is top-left). If the neighbour is in bounds, assert rd_req with rd_coord set to it. If not, hold rd_req low and skip the write for that slot. Once k=8 has been issued, go to DRAIN.
- Each read slot is tagged with (k, coordinate, valid) in a 2-deep pipeline. When rd_data returns, compute per channel: sum = sext(rd_data[c]) + sext(w[k][c]).
  - Saturate sum to [-2^(B-1), 2^(B-1)-1].
  - Register the result onto wr_data and wr_coord, with wr_req equal to the tag's valid bit.
- DRAIN: flushes the last two pipeline slots. DONE then pulses done for one cycle and returns to IDLE.
- Out-of-range events (event_x>=IMG_WIDTH or event_y>=IMG_HEIGHT) are accepted. They produce nine empty slots (no rd_req, no wr_req) and still complete with done.
- enable falling mid-event does not abort. The current event finishes, and no new event is accepted until enable is high again.
- Read and write coordinates in the same cycle are always distinct (different k), so there is no read-after-write hazard within one event.

## Timing
- Reset (async assert) clears every output to 0: event_ready, rd_req, rd_coord, wr_req, wr_coord, wr_data, busy, done. State becomes IDLE and the pipeline tags are cleared. No partial write completes after reset.
- Cycle numbering: the handshake edge is cycle 0.
  - rd_req for slot k is high in cycle k+1 (cycles 1..9).
  - rd_data for slot k is valid in cycle k+2.
  - wr_req for slot k is high in cycle k+3 (cycles 3..11).
  - done is high in cycle 12, and busy is high in cycles 1..12.
  - event_ready is low in cycles 1..12 and high again in cycle 13 if enable=1.
- Throughput: one event per 13 cycles, independent of boundary skips.
- All outputs are registered; event_ready is combinational from state and enable.

## Test plan
- Interior event: (5,5), memory preloaded (4,4)..(6,6) with channel values 0x10+4i+c, all weights 0x01 → nine writes to (4,4)..(6,6) with values 0x11+4i+c. wr_req is high in cycles 3..11 and done in cycle 12.
- Corner event: (0,0) → reads and writes only at (0,0), (1,0), (0,1), (1,1) (slots k=4,5,7,8). No requests carry negative or wrapped coordinates, and done still lands in cycle 12.
- Saturation: stored 0x7E with weight 0x05 → 0x7F. Stored 0x82 with weight 0xF0 (-16) → 0x80. Stored 0x10 with weight 0xF0 → 0x00.
- Back-to-back: two events held valid continuously → second handshake in cycle 13, with no overlap of rd_req/wr_req between the events.
- Reset mid-event: rst_n low in cycle 6 → all outputs 0 immediately and no further wr_req. After release, a fresh (5,5) event completes normally.
- Enable and bounds: enable=0 with event_valid=1 → event_ready=0 and no reads. Event (16,3) with enable=1 → accepted with no rd_req or wr_req, and done in cycle 12.
